// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: default widths, window slot
// indexing (matches the ConvolutionUnit image operand) and a width helper.
package conv_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_KERNEL_SIZE = 3;

    // Minimum bit width able to index 'value' entries; never returns 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    // Slot of window element (i,j) for an arbitrary kernel edge k; (0,0) is the MSB slot.
    function automatic int win_idx_k(input int k, input int i, input int j);
        return k * k - 1 - (i * k + j);
    endfunction

    function automatic int win_idx(input int i, input int j);
        return win_idx_k(DEF_KERNEL_SIZE, i, j);
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of storage: combinational read and registered write at the same
// column, so a row can be read out and replaced in a single accept.
module conv_line_buffer #(
    parameter int DATA_WIDTH = conv_pkg::DEF_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = conv_pkg::clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Contents need no reset: windows are only emitted once every row has been written.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_generator.sv
// Turns a raster pixel stream into flattened KxK valid-only windows (stride 1)
// using K-1 chained line buffers and a KxK shift-register window.
module conv_window_generator #(
    parameter int DATA_WIDTH   = conv_pkg::DEF_DATA_WIDTH,
    parameter int KERNEL_SIZE  = conv_pkg::DEF_KERNEL_SIZE,
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [DATA_WIDTH-1:0]                         pixel_in,
    input  logic                                          pixel_valid,
    output logic                                          pixel_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window,
    output logic                                          window_valid,
    input  logic                                          window_ready,
    output logic                                          window_last
);

    import conv_pkg::*;

    localparam int K  = KERNEL_SIZE;
    localparam int NB = KERNEL_SIZE - 1;
    localparam int WB = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;
    localparam int CW = clog2(IMAGE_WIDTH);
    localparam int RW = clog2(IMAGE_HEIGHT);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  accept;
    logic                  emit;
    logic                  frame_end;
    logic [DATA_WIDTH-1:0] lb_wdata [NB];
    logic [DATA_WIDTH-1:0] lb_rdata [NB];
    logic [DATA_WIDTH-1:0] new_col  [K];
    logic [DATA_WIDTH-1:0] sr       [K][K];
    logic [DATA_WIDTH-1:0] shifted  [K][K];
    logic [WB-1:0]         window_next;

    // Handshake: a transfer happens on a side when its valid and ready are both
    // high at the rising edge. The output slot is a single register; any pixel
    // is stalled while that slot holds an unconsumed window.
    assign pixel_ready = !(window_valid && !window_ready);
    assign accept      = pixel_valid && pixel_ready;
    assign emit        = (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign frame_end   = (row == ROW_LAST) && (col == COL_LAST);

    // Buffer 0 holds row r-1; buffer NB-1 holds the oldest row r-(K-1).
    for (genvar g = 0; g < NB; g++) begin : g_lb
        if (g == 0) begin : g_head
            assign lb_wdata[g] = pixel_in;
        end else begin : g_chain
            assign lb_wdata[g] = lb_rdata[g-1];
        end

        conv_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMAGE_WIDTH),
            .ADDR_WIDTH (CW)
        ) u_line_buffer (
            .clk   (clk),
            .en    (accept),
            .addr  (col),
            .wdata (lb_wdata[g]),
            .rdata (lb_rdata[g])
        );
    end

    for (genvar i = 0; i < K; i++) begin : g_new_col
        if (i == K - 1) begin : g_live
            assign new_col[i] = pixel_in;
        end else begin : g_buffered
            assign new_col[i] = lb_rdata[K-2-i];
        end
    end

    always_comb begin
        window_next = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                shifted[i][j] = (j == K - 1) ? new_col[i] : sr[i][j+1];
                window_next[win_idx_k(K, i, j)*DATA_WIDTH +: DATA_WIDTH] = shifted[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    sr[i][j] <= shifted[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // A new window may replace one being consumed in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            window       <= '0;
            window_valid <= 1'b0;
            window_last  <= 1'b0;
        end else if (accept && emit) begin
            window       <= window_next;
            window_valid <= 1'b1;
            window_last  <= frame_end;
        end else if (window_valid && window_ready) begin
            window_valid <= 1'b0;
            window_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_generator.sv
// Directed bench for conv_window_generator on a 4x4 frame with a 3x3 kernel.
module tb_conv_window_generator;

    localparam int DW = 32;
    localparam int K  = 3;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int WB = K * K * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] pixel_in = '0;
    logic          pixel_valid = 1'b0;
    logic          pixel_ready;
    logic [WB-1:0] window;
    logic          window_valid;
    logic          window_ready = 1'b1;
    logic          window_last;

    int n_vec = 0;
    int n_err = 0;
    bit rand_ready = 1'b0;

    logic [WB-1:0] exp_q[$];
    logic          exp_last_q[$];
    logic [WB-1:0] cap_q[$];
    logic          cap_last_q[$];

    conv_window_generator #(
        .DATA_WIDTH   (DW),
        .KERNEL_SIZE  (K),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .window       (window),
        .window_valid (window_valid),
        .window_ready (window_ready),
        .window_last  (window_last)
    );

    always #5 clk = ~clk;

    // Consumed windows, sampled mid-cycle where inputs and outputs are settled.
    always @(negedge clk) begin
        if (!reset && window_valid && window_ready) begin
            cap_q.push_back(window);
            cap_last_q.push_back(window_last);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) window_ready = 1'($urandom_range(0, 1));
    end

    // Window whose top-left pixel is (r0,c0); pixel (r,c) of a frame is base + r*IW + c + 1.
    function automatic logic [WB-1:0] mk_win(input int base, input int r0, input int c0);
        logic [WB-1:0] w;
        w = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[(K*K-1-(i*K+j))*DW +: DW] = DW'(base + (r0 + i) * IW + (c0 + j) + 1);
        return w;
    endfunction

    task automatic load_frame_expect(input int base);
        exp_q.push_back(mk_win(base, 0, 0)); exp_last_q.push_back(1'b0);
        exp_q.push_back(mk_win(base, 0, 1)); exp_last_q.push_back(1'b0);
        exp_q.push_back(mk_win(base, 1, 0)); exp_last_q.push_back(1'b0);
        exp_q.push_back(mk_win(base, 1, 1)); exp_last_q.push_back(1'b1);
    endtask

    task automatic clear_queues();
        exp_q.delete(); exp_last_q.delete(); cap_q.delete(); cap_last_q.delete();
    endtask

    // Holds the pixel until an edge accepts it; returns 1 time unit after that edge.
    task automatic send_pixel(input int value);
        int  waited;
        bit  done;
        waited = 0;
        done = 1'b0;
        pixel_in = DW'(value);
        pixel_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = pixel_ready;
            @(posedge clk); #1;
            waited++;
            if (!done && waited > 200) begin
                n_vec++; n_err++;
                $display("FAIL send_pixel_timeout: pixel %0d not accepted after %0d cycles", value, waited);
                done = 1'b1;
            end
        end
    endtask

    task automatic idle(input int cycles);
        pixel_valid = 1'b0;
        repeat (cycles) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        window_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (window_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", window_valid); end
        n_vec++;
        if (window !== '0) begin n_err++; $display("FAIL reset_window: got %h want 0", window); end
        n_vec++;
        if (window_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", window_last); end
        n_vec++;
        if (pixel_ready !== 1'b1) begin n_err++; $display("FAIL reset_pixel_ready: got %b want 1", pixel_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_first_window();
        clear_queues();
        for (int p = 1; p <= 10; p++) send_pixel(p);
        n_vec++;
        if (window_valid !== 1'b0) begin n_err++; $display("FAIL first_early_valid: got %b want 0 after pixel 10", window_valid); end
        send_pixel(11);
        n_vec++;
        if (window_valid !== 1'b1) begin n_err++; $display("FAIL first_latency: got valid %b want 1 after pixel 11", window_valid); end
        n_vec++;
        if (window !== mk_win(0, 0, 0)) begin n_err++; $display("FAIL first_window: got %h want %h", window, mk_win(0, 0, 0)); end
        for (int p = 12; p <= 16; p++) send_pixel(p);
        idle(4);
    endtask

    task automatic test_frame_sequence();
        clear_queues();
        load_frame_expect(0);
        for (int p = 1; p <= 16; p++) send_pixel(p);
        idle(4);
        n_vec++;
        if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL seq_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int n = 0; n < exp_q.size() && n < cap_q.size(); n++) begin
            n_vec++;
            if (cap_q[n] !== exp_q[n] || cap_last_q[n] !== exp_last_q[n]) begin
                n_err++;
                $display("FAIL seq_window%0d: got %h last %b want %h last %b", n, cap_q[n], cap_last_q[n], exp_q[n], exp_last_q[n]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_queues();
        load_frame_expect(0);
        window_ready = 1'b0;
        for (int p = 1; p <= 11; p++) send_pixel(p);
        pixel_in = DW'(12);
        pixel_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_vec++;
            if (pixel_ready !== 1'b0 || window_valid !== 1'b1 || window !== mk_win(0, 0, 0)) begin
                n_err++;
                $display("FAIL bp_hold%0d: got ready %b valid %b win %h want ready 0 valid 1 win %h",
                         n, pixel_ready, window_valid, window, mk_win(0, 0, 0));
            end
            @(posedge clk); #1;
        end
        window_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (pixel_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got ready %b want 1", pixel_ready); end
        @(posedge clk); #1;
        n_vec++;
        if (window_valid !== 1'b1 || window !== mk_win(0, 0, 1)) begin
            n_err++; $display("FAIL bp_second: got valid %b win %h want 1 %h", window_valid, window, mk_win(0, 0, 1));
        end
        for (int p = 13; p <= 16; p++) send_pixel(p);
        idle(4);
        n_vec++;
        if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int n = 0; n < exp_q.size() && n < cap_q.size(); n++) begin
            n_vec++;
            if (cap_q[n] !== exp_q[n] || cap_last_q[n] !== exp_last_q[n]) begin
                n_err++;
                $display("FAIL bp_window%0d: got %h last %b want %h last %b", n, cap_q[n], cap_last_q[n], exp_q[n], exp_last_q[n]);
            end
        end
    endtask

    task automatic test_random_gaps();
        clear_queues();
        load_frame_expect(0);
        rand_ready = 1'b1;
        for (int p = 1; p <= 16; p++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send_pixel(p);
        end
        pixel_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        rand_ready = 1'b0;
        window_ready = 1'b1;
        idle(4);
        n_vec++;
        if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int n = 0; n < exp_q.size() && n < cap_q.size(); n++) begin
            n_vec++;
            if (cap_q[n] !== exp_q[n] || cap_last_q[n] !== exp_last_q[n]) begin
                n_err++;
                $display("FAIL rand_window%0d: got %h last %b want %h last %b", n, cap_q[n], cap_last_q[n], exp_q[n], exp_last_q[n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        load_frame_expect(0);
        load_frame_expect(100);
        for (int p = 1; p <= 16; p++) send_pixel(p);
        for (int p = 101; p <= 116; p++) send_pixel(p);
        idle(4);
        n_vec++;
        if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int n = 0; n < exp_q.size() && n < cap_q.size(); n++) begin
            n_vec++;
            if (cap_q[n] !== exp_q[n] || cap_last_q[n] !== exp_last_q[n]) begin
                n_err++;
                $display("FAIL b2b_window%0d: got %h last %b want %h last %b", n, cap_q[n], cap_last_q[n], exp_q[n], exp_last_q[n]);
            end
        end
    endtask

    task automatic test_mid_reset();
        clear_queues();
        for (int p = 1; p <= 7; p++) send_pixel(p);
        pixel_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_vec++;
        if (window_valid !== 1'b0 || window !== '0 || window_last !== 1'b0) begin
            n_err++; $display("FAIL midreset_clear: got valid %b last %b win %h want 0 0 0", window_valid, window_last, window);
        end
        load_frame_expect(0);
        for (int p = 1; p <= 16; p++) send_pixel(p);
        idle(4);
        n_vec++;
        if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL midreset_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int n = 0; n < exp_q.size() && n < cap_q.size(); n++) begin
            n_vec++;
            if (cap_q[n] !== exp_q[n] || cap_last_q[n] !== exp_last_q[n]) begin
                n_err++;
                $display("FAIL midreset_window%0d: got %h last %b want %h last %b", n, cap_q[n], cap_last_q[n], exp_q[n], exp_last_q[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_frame_sequence();
        test_backpressure();
        test_random_gaps();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
